// File: rtl/mux_pipe_nto1.sv
// Pipelined N-to-1 valid/ready multiplexer with fixed or round-robin channel grant.
// Optional even-parity sideband on the output word when MUX_PIPE_PARITY_EN is defined.
module mux_pipe_nto1 #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 16,
    parameter int SEL_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_WIDTH-1:0]      sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_WIDTH-1:0]      out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_parity
);

    localparam logic [SEL_WIDTH:0] CH_LIM = (SEL_WIDTH+1)'(CHANNELS);

    logic [SEL_WIDTH-1:0] rr_ptr;
    logic [SEL_WIDTH-1:0] rr_cand;
    logic                 rr_found;
    logic [SEL_WIDTH:0]   rr_idx;

    logic [SEL_WIDTH-1:0] cand;
    logic                 cand_ok;
    logic [WIDTH-1:0]     cand_data;
    logic [SEL_WIDTH:0]   ptr_inc;
    logic [SEL_WIDTH-1:0] rr_next;

    logic                 s1_valid;
    logic [WIDTH-1:0]     s1_data;
    logic [SEL_WIDTH-1:0] s1_chan;

    logic                 s2_adv;
    logic                 can_accept;
    logic                 xfer;

    // Search starts at rr_ptr and wraps modulo CHANNELS; first valid channel wins.
    always_comb begin
        rr_found = 1'b0;
        rr_cand  = '0;
        rr_idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rr_idx = {1'b0, rr_ptr} + (SEL_WIDTH+1)'(i);
            if (rr_idx >= CH_LIM)
                rr_idx = rr_idx - CH_LIM;
            if (!rr_found && in_valid[rr_idx[SEL_WIDTH-1:0]]) begin
                rr_found = 1'b1;
                rr_cand  = rr_idx[SEL_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        cand    = '0;
        cand_ok = 1'b0;
        if (mode) begin
            cand    = rr_cand;
            cand_ok = rr_found;
        end else begin
            cand    = sel;
            cand_ok = ({1'b0, sel} < CH_LIM);
        end
    end

    assign cand_data  = in_data[int'(cand)*WIDTH +: WIDTH];
    assign s2_adv     = !out_valid || out_ready;
    assign can_accept = !s1_valid || s2_adv;
    assign xfer       = rst_n && cand_ok && can_accept && in_valid[cand];

    // Ready is forced low while reset is asserted so no producer sees a grant.
    always_comb begin
        in_ready = '0;
        if (rst_n && cand_ok && can_accept)
            in_ready[cand] = 1'b1;
    end

    assign ptr_inc = {1'b0, cand} + (SEL_WIDTH+1)'(1);
    assign rr_next = (ptr_inc == CH_LIM) ? '0 : ptr_inc[SEL_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer && mode) begin
            rr_ptr <= rr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_chan  <= '0;
        end else if (can_accept) begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_data <= cand_data;
                s1_chan <= cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_data;
                out_chan <= s1_chan;
            end
        end
    end

`ifdef MUX_PIPE_PARITY_EN
    logic s1_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_parity  <= 1'b0;
            out_parity <= 1'b0;
        end else begin
            if (can_accept && xfer)
                s1_parity <= ^cand_data;
            if (s2_adv && s1_valid)
                out_parity <= s1_parity;
        end
    end
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe_nto1.sv
// Directed bench for mux_pipe_nto1: grant table, latency, round-robin, wrap, stall, reset, illegal select.
module tb_mux_pipe_nto1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic [15:0]  in_valid;
    logic [15:0]  in_ready;
    logic         mode;
    logic [3:0]   sel;
    logic [7:0]   out_data;
    logic [3:0]   out_chan;
    logic         out_valid;
    logic         out_ready;
    logic         out_parity;

    logic [95:0]  d12_data;
    logic [11:0]  d12_valid;
    logic [11:0]  d12_ready;
    logic         d12_mode;
    logic [3:0]   d12_sel;
    logic [7:0]   d12_out_data;
    logic [3:0]   d12_out_chan;
    logic         d12_out_valid;
    logic         d12_out_ready;
    logic         d12_out_parity;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_pipe_nto1 #(.WIDTH(8), .CHANNELS(16), .SEL_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
        .out_parity(out_parity)
    );

    mux_pipe_nto1 #(.WIDTH(8), .CHANNELS(12), .SEL_WIDTH(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_data(d12_data), .in_valid(d12_valid),
        .in_ready(d12_ready), .mode(d12_mode), .sel(d12_sel), .out_data(d12_out_data),
        .out_chan(d12_out_chan), .out_valid(d12_out_valid), .out_ready(d12_out_ready),
        .out_parity(d12_out_parity)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_par(input logic [7:0] d);
`ifdef MUX_PIPE_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [7:0] v);
        in_data[k*8 +: 8] = v;
    endtask

    typedef struct {
        logic        mode;
        logic [3:0]  sel;
        logic [15:0] valid;
        logic [15:0] exp_ready;
    } vec_t;

    vec_t tbl [8];

    logic [3:0]  rr_seq [5];
    logic [7:0]  rr_dat [5];
    logic [7:0]  rx [$];
    logic [7:0]  held;
    int          sent;
    logic        hs_in;

    initial begin
        tbl[0] = '{1'b0, 4'd5,  16'h0000, 16'h0020};
        tbl[1] = '{1'b0, 4'd0,  16'h0000, 16'h0001};
        tbl[2] = '{1'b0, 4'd15, 16'hFFFF, 16'h8000};
        tbl[3] = '{1'b0, 4'd9,  16'h0000, 16'h0200};
        tbl[4] = '{1'b1, 4'd0,  16'h0000, 16'h0000};
        tbl[5] = '{1'b1, 4'd0,  16'h0030, 16'h0010};
        tbl[6] = '{1'b1, 4'd7,  16'h8000, 16'h8000};
        tbl[7] = '{1'b1, 4'd0,  16'h0041, 16'h0001};
        rr_seq = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd0};
        rr_dat = '{8'h10, 8'h55, 8'hAA, 8'hFF, 8'h10};

        rst_n = 1'b0; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;
        d12_data = {12{8'h3C}}; d12_valid = '1; d12_mode = 1'b0; d12_sel = 4'd13; d12_out_ready = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 16'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Combinational grant table; valids are dropped before the next edge so no word moves.
        for (int i = 0; i < 8; i++) begin
            tick();
            mode = tbl[i].mode; sel = tbl[i].sel; in_valid = tbl[i].valid;
            #1;
            check($sformatf("grant_tbl[%0d]", i), in_ready, tbl[i].exp_ready);
            in_valid = '0;
        end

        // Fixed select, 2-cycle latency.
        tick();
        mode = 1'b0; sel = 4'd5; set_ch(5, 8'hA5); in_valid = 16'h0020;
        #1;
        check("fix_in_ready", in_ready, 16'h0020);
        tick();
        in_valid = '0;
        check("fix_lat1_valid", out_valid, 1'b0);
        tick();
        check("fix_valid", out_valid, 1'b1);
        check("fix_data", out_data, 8'hA5);
        check("fix_chan", out_chan, 4'd5);
        check("fix_parity", out_parity, exp_par(8'hA5));
        tick();
        check("fix_drain", out_valid, 1'b0);

        // Round-robin fairness across channels 0,5,10,15.
        mode = 1'b1;
        set_ch(0, 8'h10); set_ch(5, 8'h55); set_ch(10, 8'hAA); set_ch(15, 8'hFF);
        in_valid = 16'h8421;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (n == 0) check("rr_fill", out_valid, 1'b0);
            else begin
                check($sformatf("rr_valid[%0d]", n-1), out_valid, 1'b1);
                check($sformatf("rr_chan[%0d]", n-1), out_chan, rr_seq[n-1]);
                check($sformatf("rr_data[%0d]", n-1), out_data, rr_dat[n-1]);
            end
        end
        in_valid = '0;
        tick();
        check("rr_chan[4]", out_chan, rr_seq[4]);
        check("rr_valid[4]", out_valid, 1'b1);
        tick();
        check("rr_drain", out_valid, 1'b0);

        // Wrap: grant ch14 puts the pointer at 15, then ch0 and ch1 follow.
        set_ch(14, 8'h4E); set_ch(0, 8'h01); set_ch(1, 8'h02);
        in_valid = 16'h4000;
        #1;
        check("wrap_rdy14", in_ready, 16'h4000);
        tick();
        in_valid = 16'h0003;
        #1;
        check("wrap_rdy0", in_ready, 16'h0001);
        tick();
        check("wrap_rdy1", in_ready, 16'h0002);
        check("wrap_out14", out_chan, 4'd14);
        tick();
        in_valid = '0;
        check("wrap_out0", out_chan, 4'd0);
        check("wrap_out0_data", out_data, 8'h01);
        tick();
        check("wrap_out1", out_chan, 4'd1);
        check("wrap_out1_valid", out_valid, 1'b1);
        tick();

        // Backpressure: consumer stalls during cycles 3..6.
        mode = 1'b0; sel = 4'd3; sent = 0; held = '0;
        for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 6) ? 16'h0008 : 16'h0;
            set_ch(3, 8'(sent + 1));
            #1;
            if (sent < 6)
                check($sformatf("bp_ready[%0d]", c), in_ready[3], (c >= 3 && c <= 6) ? 1'b0 : 1'b1);
            if (c == 3) held = out_data;
            if (c > 3 && c <= 6) check($sformatf("bp_hold[%0d]", c), out_data, held);
            hs_in = in_valid[3] && in_ready[3];
            if (out_valid && out_ready) rx.push_back(out_data);
            tick();
            if (hs_in) sent++;
        end
        in_valid = '0; out_ready = 1'b1;
        check("bp_count", rx.size(), 6);
        for (int i = 0; i < rx.size() && i < 6; i++)
            check($sformatf("bp_word[%0d]", i), rx[i], 8'(i + 1));
        check("bp_held_w2", held, 8'h02);

        // Illegal select on the 12-channel instance, which has seen all-valid throughout.
        check("ill_ready", d12_ready, 12'h0);
        check("ill_valid", d12_out_valid, 1'b0);

        // Reset mid-stream with both stages full.
        mode = 1'b0; sel = 4'd3; set_ch(3, 8'h77); in_valid = 16'h0008; out_ready = 1'b0;
        tick(); tick(); tick();
        check("mid_full", out_valid, 1'b1);
        check("mid_full_rdy", in_ready, 16'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 8'h0);
        check("mid_rst_chan", out_chan, 4'h0);
        check("mid_rst_parity", out_parity, 1'b0);
        check("mid_rst_rdy", in_ready, 16'h0);
        tick();
        mode = 1'b1; in_valid = '0; out_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", out_valid, 1'b0);
        check("post_rst_rdy", in_ready, 16'h0);
        in_valid = 16'hFFFF;
        #1;
        check("post_rst_ptr", in_ready, 16'h0001);
        in_valid = '0;

        // Legal select on the 12-channel instance.
        d12_sel = 4'd11;
        #1;
        check("d12_legal_rdy", d12_ready, 12'h800);
        tick(); tick();
        check("d12_legal_out", d12_out_chan, 4'd11);
        check("d12_legal_valid", d12_out_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_pipe_nto1.md
Name: mux_pipe_nto1

Overview:
- Parametrised, pipelined N-to-1 data multiplexer; successor to the combinational 16-to-1 byte mux tree.
- Adds per-channel valid/ready handshake, a 2-stage registered select path with backpressure, and a round-robin auto-select mode alongside fixed select.
- Sits between multiple producer channels and a single consumer; reports which channel each output word came from.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 16, number of input channels; legal range 2..64.
- SEL_WIDTH, 4, select/channel-index width; must equal $clog2(CHANNELS).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  CHANNELS*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = fixed select from sel; 1 = round-robin.
- sel  input  SEL_WIDTH  channel index used in fixed mode.
- out_data  output  WIDTH  selected word.
- out_chan  output  SEL_WIDTH  source channel of out_data.
- out_valid  output  1  out_data/out_chan valid.
- out_ready  input  1  consumer ready.
- out_parity  output  1  even parity of out_data (see Optional Feature).

Behaviour:
- Reset (async, rst_n low): out_data=0, out_chan=0, out_valid=0, out_parity=0, both pipeline stage valids=0, rr_ptr=0. Since in_ready is combinational, it reads 0 during reset.
- Pipeline: S1 register (data, chan, valid) feeds S2 output register (out_*). Latency from input handshake to out_valid is exactly 2 cycles with no stall.
- Advance rules:
  - S2 loads from S1 when !out_valid or out_ready.
  - S1 may load a new word when S1 is empty or S1 is moving into S2 this cycle (can_accept).
  - Full throughput: 1 word per cycle when out_ready is held high.
- Grant selection (combinational, per cycle):
  - mode=0: candidate c = sel. If sel >= CHANNELS, there is no candidate and all in_ready=0.
  - mode=1: c = the first channel k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ..., wrapping mod CHANNELS. No valid channel means no candidate.
- Handshake:
  - in_ready[c] = can_accept; all other in_ready bits are 0.
  - Transfer occurs when in_valid[c] && in_ready[c]. S1 then captures in_data[c] and c.
  - in_ready does not depend on in_valid in mode=0. In mode=1 it depends only through the candidate search, so there are no combinational loops.
- Round-robin pointer: on each mode=1 transfer, rr_ptr <= (c+1) mod CHANNELS. rr_ptr is unchanged on mode=0 transfers and on idle cycles.
- Mode/sel changes: sampled every cycle and affect only the next grant. Words already in S1/S2 are delivered unchanged, in order.
- Backpressure:
  - out_ready=0 with out_valid=1 holds out_* stable.
  - S1 fills and holds; in_ready goes 0 once both stages are full.
  - No word is dropped or duplicated.
- Reset mid-operation: in-flight words are discarded and all outputs return to reset values immediately.

Optional Feature:
- Macro: MUX_PIPE_PARITY_EN.
- Defined: S1 computes ^in_data[c] on capture and carries it to S2. out_parity = even-parity bit of out_data, aligned with out_valid, and held stable under stall.
- Undefined: out_parity is tied to 0 and no parity logic is instantiated. The port list is unchanged.

Test Plan:
- Reset/idle: rst_n=0 mid-stream with S1 and S2 full -> out_valid=0, out_data=0, out_chan=0, in_ready=0 while low. After release with mode=1 and all in_valid=0 -> no transfer, rr_ptr stays 0.
- Fixed select latency: mode=0, sel=5, in_data ch5=0xA5, in_valid[5]=1 for one cycle, out_ready=1 -> in_ready=16'h0020. Two cycles later out_valid=1, out_data=0xA5, out_chan=5. With MUX_PIPE_PARITY_EN, out_parity=0.
- Round-robin fairness: mode=1, in_valid=16'h8421 held, ch0=0x10, ch5=0x55, ch10=0xAA, ch15=0xFF, out_ready=1 -> output chan sequence 0,5,10,15,0, one word per cycle after a 2-cycle fill.
- Wrap-around: mode=1, rr_ptr=15 (after a grant to ch14), in_valid=16'h0003 -> next grant ch0, then ch1.
- Backpressure: mode=0, sel=3, stream 0x01..0x06 with out_ready low for cycles 3-6 -> in_ready drops after 2 buffered words, out_data holds stable, and the final output is exactly 0x01..0x06 in order.
- Illegal select: CHANNELS=12, SEL_WIDTH=4, mode=0, sel=13, in_valid all 1 -> in_ready=0 and out_valid stays 0.
